// File: rtl/reg_mm_arbiter.sv
// ============================================================================
// Module      : reg_mm_arbiter
// Description : Round-robin arbiter from N Avalon-MM register masters onto one
//               register slave; optional read timeout via REG_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_mm_arbiter #(
    parameter int N_MASTERS      = 2,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_MASTERS-1:0]             m_read,
    input  logic [N_MASTERS-1:0]             m_write,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_address,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_writedata,
    output logic [N_MASTERS-1:0]             m_waitrequest,
    output logic [N_MASTERS-1:0]             m_readdatavalid,
    output logic [DATA_WIDTH-1:0]            m_readdata,
    output logic                             s_read,
    output logic                             s_write,
    output logic [ADDR_WIDTH-1:0]            s_address,
    output logic [DATA_WIDTH-1:0]            s_writedata,
    input  logic [DATA_WIDTH-1:0]            s_readdata,
    input  logic                             s_readdatavalid,
    output logic                             timeout_flag
);

    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2
    } state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_grant;
    logic [IDX_W-1:0]       r_ptr;

    logic [N_MASTERS-1:0]   w_req;
    logic                   w_found;
    logic [IDX_W-1:0]       w_winner;
    logic [IDX_W:0]         w_cand;
    logic                   w_sel_rd;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [DATA_WIDTH-1:0]  w_sel_wdata;

    assign w_req = m_read | m_write;

    // Search starts one past the last granted index and wraps around.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            w_cand = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (w_cand >= (IDX_W+1)'(N_MASTERS))
                w_cand = w_cand - (IDX_W+1)'(N_MASTERS);
            if (!w_found && w_req[w_cand[IDX_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[IDX_W-1:0];
            end
        end
    end

    assign w_sel_rd    = m_read[w_winner];
    assign w_sel_addr  = m_address[int'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_wdata = m_writedata[int'(w_winner)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        m_waitrequest = '1;
        if (r_state == ST_ISSUE)
            m_waitrequest[r_grant] = 1'b0;
    end

`ifdef REG_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] c_timeout_word = 32'hDEADBEEF;
    localparam logic [DATA_WIDTH-1:0] c_timeout_data = DATA_WIDTH'(c_timeout_word);
    logic [TO_W-1:0] r_to_cnt;
`else
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_grant         <= '0;
            r_ptr           <= IDX_W'(N_MASTERS - 1);
            s_read          <= 1'b0;
            s_write         <= 1'b0;
            s_address       <= '0;
            s_writedata     <= '0;
            m_readdata      <= '0;
            m_readdatavalid <= '0;
`ifdef REG_ARB_TIMEOUT_EN
            r_to_cnt        <= '0;
            timeout_flag    <= 1'b0;
`endif
        end else begin
            m_readdatavalid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant     <= w_winner;
                        s_address   <= w_sel_addr;
                        s_writedata <= w_sel_wdata;
                        s_read      <= w_sel_rd;
                        s_write     <= !w_sel_rd;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    s_read  <= 1'b0;
                    s_write <= 1'b0;
                    r_ptr   <= r_grant;
                    r_state <= s_read ? ST_WAIT_RD : ST_IDLE;
`ifdef REG_ARB_TIMEOUT_EN
                    r_to_cnt <= '0;
                    // Writing the all-ones address is the software clear for the sticky flag.
                    if (s_write && (&s_address))
                        timeout_flag <= 1'b0;
`endif
                end
                ST_WAIT_RD: begin
                    if (s_readdatavalid) begin
                        m_readdata               <= s_readdata;
                        m_readdatavalid[r_grant] <= 1'b1;
                        r_state                  <= ST_IDLE;
                    end
`ifdef REG_ARB_TIMEOUT_EN
                    else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        m_readdata               <= c_timeout_data;
                        m_readdatavalid[r_grant] <= 1'b1;
                        timeout_flag             <= 1'b1;
                        r_state                  <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_mm_arbiter.sv
// ============================================================================
// Module      : tb_reg_mm_arbiter
// Description : Scoreboard bench for reg_mm_arbiter with a 1-cycle slave model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_mm_arbiter;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    m_read = '0;
    logic [N-1:0]    m_write = '0;
    logic [N*AW-1:0] m_address = '0;
    logic [N*DW-1:0] m_writedata = '0;
    logic [N-1:0]    m_waitrequest;
    logic [N-1:0]    m_readdatavalid;
    logic [DW-1:0]   m_readdata;
    logic            s_read;
    logic            s_write;
    logic [AW-1:0]   s_address;
    logic [DW-1:0]   s_writedata;
    logic [DW-1:0]   s_readdata = '0;
    logic            s_readdatavalid = 1'b0;
    logic            timeout_flag;

    reg_mm_arbiter #(
        .N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_read(m_read), .m_write(m_write),
        .m_address(m_address), .m_writedata(m_writedata),
        .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid),
        .m_readdata(m_readdata),
        .s_read(s_read), .s_write(s_write),
        .s_address(s_address), .s_writedata(s_writedata),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    typedef struct { bit is_rd; int mst; logic [AW-1:0] addr; logic [DW-1:0] data; int cyc; } slv_t;
    typedef struct { int mst; logic [DW-1:0] data; int cyc; } rsp_t;

    slv_t slv_q[$];
    rsp_t rsp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    logic          slave_silent = 1'b0;
    logic [DW-1:0] slave_data   = '0;
    logic          inject_rdv   = 1'b0;
    logic          slv_pend     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave answers one cycle after it sees s_read; inject_rdv forces a stray valid.
    always begin
        @(negedge clk);
        slv_pend = s_read && !slave_silent;
        @(posedge clk);
        #2;
        s_readdatavalid = slv_pend | inject_rdv;
        s_readdata      = slv_pend ? slave_data : 32'h0BAD_0BAD;
    end

    slv_t          se;
    rsp_t          re;
    logic [N-1:0]  wexp;
    logic [N-1:0]  vexp;

    always @(negedge clk) begin
        if (s_read || s_write) begin
            if (slv_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL slv_unexpected: got rd=%0b wr=%0b addr=%0h, required no transfer (cycle %0d)",
                         s_read, s_write, s_address, cyc);
            end else begin
                se   = slv_q.pop_front();
                wexp = ~(N'(1) << se.mst);
                check("slv_read",  s_read,  se.is_rd);
                check("slv_write", s_write, !se.is_rd);
                check("slv_addr",  s_address, se.addr);
                if (!se.is_rd) check("slv_wdata", s_writedata, se.data);
                check("issue_waitreq", m_waitrequest, wexp);
                check("issue_cycle", cyc, se.cyc);
            end
        end else begin
            check("idle_waitreq", m_waitrequest, {N{1'b1}});
        end
        if (m_readdatavalid != '0) begin
            if (rsp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rsp_unexpected: got rdv=%0b data=%0h, required no response (cycle %0d)",
                         m_readdatavalid, m_readdata, cyc);
            end else begin
                re   = rsp_q.pop_front();
                vexp = N'(1) << re.mst;
                check("rsp_valid", m_readdatavalid, vexp);
                check("rsp_data",  m_readdata, re.data);
                check("rsp_cycle", cyc, re.cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int m, input bit rd, input bit wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_read[m]  = rd;
        m_write[m] = wr;
        m_address[m*AW +: AW]   = a;
        m_writedata[m*DW +: DW] = d;
    endtask

    task automatic push_slv(input bit rd, input int m, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input int c);
        slv_t t;
        t.is_rd = rd; t.mst = m; t.addr = a; t.data = d; t.cyc = c;
        slv_q.push_back(t);
    endtask

    task automatic push_rsp(input int m, input logic [DW-1:0] d, input int c);
        rsp_t t;
        t.mst = m; t.data = d; t.cyc = c;
        rsp_q.push_back(t);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_read"},   s_read, 1'b0);
        check({tag, "_s_write"},  s_write, 1'b0);
        check({tag, "_s_addr"},   s_address, '0);
        check({tag, "_s_wdata"},  s_writedata, '0);
        check({tag, "_m_rdata"},  m_readdata, '0);
        check({tag, "_m_rdv"},    m_readdatavalid, '0);
        check({tag, "_waitreq"},  m_waitrequest, {N{1'b1}});
        check({tag, "_toflag"},   timeout_flag, 1'b0);
    endtask

    int c0;

    initial begin
        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(2);

        // Single write from master 0
        c0 = cyc;
        set_req(0, 0, 1, 16'h0402, 32'h1234);
        push_slv(0, 0, 16'h0402, 32'h1234, c0 + 1);
        tick(1);
        set_req(0, 0, 0, '0, '0);
        tick(3);
        check("addr_hold", s_address, 16'h0402);

        // Single read from master 1, slave returns 5
        c0 = cyc;
        slave_data = 32'h5;
        set_req(1, 1, 0, 16'h0400, '0);
        push_slv(1, 1, 16'h0400, '0, c0 + 1);
        push_rsp(1, 32'h5, c0 + 3);
        tick(1);
        set_req(1, 0, 0, '0, '0);
        tick(4);

        // Fresh reset, both masters hold writes: grants 0,1,0,1
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        c0 = cyc;
        set_req(0, 0, 1, 16'h0010, 32'h0000_00A0);
        set_req(1, 0, 1, 16'h0020, 32'h0000_00B1);
        push_slv(0, 0, 16'h0010, 32'h0000_00A0, c0 + 1);
        push_slv(0, 1, 16'h0020, 32'h0000_00B1, c0 + 3);
        push_slv(0, 0, 16'h0010, 32'h0000_00A0, c0 + 5);
        push_slv(0, 1, 16'h0020, 32'h0000_00B1, c0 + 7);
        tick(7);
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        tick(3);

        // Read and write together from master 0 is a read
        c0 = cyc;
        slave_data = 32'h0000_CAFE;
        set_req(0, 1, 1, 16'h0033, 32'h77);
        push_slv(1, 0, 16'h0033, '0, c0 + 1);
        push_rsp(0, 32'h0000_CAFE, c0 + 3);
        tick(1);
        set_req(0, 0, 0, '0, '0);
        tick(4);

        // Sole requester held: back-to-back writes every 2 cycles
        c0 = cyc;
        set_req(1, 0, 1, 16'h0055, 32'h5555_0001);
        push_slv(0, 1, 16'h0055, 32'h5555_0001, c0 + 1);
        push_slv(0, 1, 16'h0055, 32'h5555_0001, c0 + 3);
        push_slv(0, 1, 16'h0055, 32'h5555_0001, c0 + 5);
        tick(5);
        set_req(1, 0, 0, '0, '0);
        tick(2);

        // Stray s_readdatavalid while idle must be ignored
        inject_rdv = 1'b1;
        tick(2);
        inject_rdv = 1'b0;
        tick(3);

`ifdef REG_ARB_TIMEOUT_EN
        // Silent slave: timeout response 16 cycles after WAIT_RD entry
        c0 = cyc;
        slave_silent = 1'b1;
        set_req(1, 1, 0, 16'h0500, '0);
        push_slv(1, 1, 16'h0500, '0, c0 + 1);
        push_rsp(1, 32'hDEAD_BEEF, c0 + 18);
        tick(1);
        set_req(1, 0, 0, '0, '0);
        tick(18);
        check("timeout_flag_set", timeout_flag, 1'b1);
        inject_rdv = 1'b1;
        tick(1);
        inject_rdv = 1'b0;
        tick(3);
        check("timeout_flag_sticky", timeout_flag, 1'b1);
        slave_silent = 1'b0;
        c0 = cyc;
        set_req(0, 0, 1, 16'hFFFF, 32'h0);
        push_slv(0, 0, 16'hFFFF, 32'h0, c0 + 1);
        tick(1);
        set_req(0, 0, 0, '0, '0);
        tick(1);
        check("timeout_flag_clear", timeout_flag, 1'b0);
        tick(2);
`endif

        // Reset while waiting on a silent slave aborts the read
        c0 = cyc;
        slave_silent = 1'b1;
        set_req(0, 1, 0, 16'h0044, '0);
        push_slv(1, 0, 16'h0044, '0, c0 + 1);
        tick(1);
        set_req(0, 0, 0, '0, '0);
        tick(2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        tick(2);
        rst_n = 1'b1;
        slave_silent = 1'b0;
        tick(20);

        // Arbiter usable after the abort; master 0 first
        c0 = cyc;
        set_req(0, 0, 1, 16'h0077, 32'h0000_7777);
        set_req(1, 0, 1, 16'h0088, 32'h0000_8888);
        push_slv(0, 0, 16'h0077, 32'h0000_7777, c0 + 1);
        tick(1);
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        tick(4);
        check("final_toflag", timeout_flag, 1'b0);

        check("slv_queue_drained", slv_q.size(), 0);
        check("rsp_queue_drained", rsp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
